// File: rtl/hack_ioctl_pkg.sv
// Types and constants shared by the ioctl ROM loader and the upload (read-back) path.
// Both sides must agree on byte order so that a saved image reloads byte-identical.
package hack_ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE
    } upload_state_t;

    localparam int BYTE_HI_FIRST = 1;
    localparam int IOCTL_ADDR_W  = 25;

    // Even byte addresses carry the high byte of a word when BYTE_HI_FIRST is set.
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic odd_byte);
        if (BYTE_HI_FIRST != 0)
            return odd_byte ? word[7:0] : word[15:8];
        return odd_byte ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/hack_rom_upload_if.sv
// Bundle of the hps_io ioctl upload signals and the dpram read port.
// master is the hps_io / memory side, slave is the upload engine.
interface hack_rom_upload_if
    import hack_ioctl_pkg::*;
#(
    parameter int ADDR_W = 15
);

    logic                    ioctl_upload;
    logic                    ioctl_rd;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rd;
    logic [15:0]             mem_q;
    logic                    busy;

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, mem_q,
        input  ioctl_din, ioctl_wait, mem_addr, mem_rd, busy
    );

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, mem_q,
        output ioctl_din, ioctl_wait, mem_addr, mem_rd, busy
    );

endinterface

// File: rtl/hack_rom_upload.sv
// Byte-wise read-back of 16-bit program memory for the hps_io upload path,
// with a one-word cache so the second byte of each word needs no memory access.
module hack_rom_upload
    import hack_ioctl_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int MEM_WORDS  = 32768,
    parameter int RD_LATENCY = 1
) (
    input logic              clk_sys,
    input logic              reset,
    hack_rom_upload_if.slave bus
);

    localparam logic [IOCTL_ADDR_W-1:0] BYTE_LIMIT = IOCTL_ADDR_W'(2 * MEM_WORDS);
    localparam logic [1:0]              LAT_LAST   = 2'(RD_LATENCY - 1);

    upload_state_t     state;
    logic [7:0]        din_q;
    logic              wait_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              busy_q;
    logic              upload_q;
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_tag;
    logic [15:0]       cache_data;
    logic              pend_odd;
    logic [1:0]        lat_cnt;

    logic [ADDR_W-1:0] waddr;
    logic              odd_byte;
    logic              upload_rise;
    logic              out_of_range;
    logic              hit;

    // A new session may follow memory writes, so a rising upload never hits a stale tag.
    assign waddr        = bus.ioctl_addr[ADDR_W:1];
    assign odd_byte     = bus.ioctl_addr[0];
    assign upload_rise  = bus.ioctl_upload && !upload_q;
    assign out_of_range = bus.ioctl_addr >= BYTE_LIMIT;
    assign hit          = cache_valid && !upload_rise && (cache_tag == waddr);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            din_q       <= 8'h00;
            wait_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            upload_q    <= 1'b0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= 16'h0000;
            pend_odd    <= 1'b0;
            lat_cnt     <= 2'd0;
        end else begin
            upload_q <= bus.ioctl_upload;
            mem_rd_q <= 1'b0;
            if (upload_rise)
                cache_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.ioctl_rd && bus.ioctl_upload) begin
                        if (out_of_range) begin
                            din_q <= 8'h00;
                        end else if (hit) begin
                            din_q <= pick_byte(cache_data, odd_byte);
                        end else begin
                            mem_addr_q <= waddr;
                            mem_rd_q   <= 1'b1;
                            wait_q     <= 1'b1;
                            busy_q     <= 1'b1;
                            pend_odd   <= odd_byte;
                            lat_cnt    <= 2'd0;
                            state      <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (!bus.ioctl_upload) begin
                        wait_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        cache_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (lat_cnt == LAT_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end

                CAPTURE: begin
                    // mem_addr_q is still the fetched word, so it doubles as the new tag.
                    if (!bus.ioctl_upload) begin
                        cache_valid <= 1'b0;
                    end else begin
                        cache_data  <= bus.mem_q;
                        cache_tag   <= mem_addr_q;
                        cache_valid <= 1'b1;
                        din_q       <= pick_byte(bus.mem_q, pend_odd);
                    end
                    wait_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    wait_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.busy       = busy_q;

endmodule
